// File: rtl/mod_n_count_ctrl.sv
`default_nettype none
// mod_n_count_ctrl: start/stop mod-N sequencer steering a loadable counter through its load port.
// Optional MODN_PRESCALER_EN inserts a PRESCALE-clock prescaler ahead of each count advance. Rev 1.0
module mod_n_count_ctrl #(
    parameter int CNT_W    = 4,
    parameter int PRESCALE = 10,
    parameter int PS_W     = $clog2(PRESCALE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [CNT_W-1:0] mod_n,
    input  logic [CNT_W-1:0] count_i,
    output logic             ctr_load,
    output logic [CNT_W-1:0] ctr_load_data,
    output logic             running,
    output logic             tc_pulse,
    output logic             cfg_err
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    if (PRESCALE < 1 || PS_W < 1) begin : g_bad_cfg
        $error("mod_n_count_ctrl: PRESCALE must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] last;
    logic             cfg_err_q, cfg_err_d;
    logic             tc_q, tc_d;
    logic             in_run;
    logic             tick;

    assign in_run = (state_q == S_RUN);
    // n_q==0 encodes 2^CNT_W, so the wrap of the subtraction yields the all-ones last count.
    assign last   = n_q - CNT_W'(1);

`ifdef MODN_PRESCALER_EN
    localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    assign tick = in_run && (ps_q == C_PS_LAST);

    always_comb begin
        ps_d = ps_q + PS_W'(1);
        if (clear || stop || !in_run || tick) begin
            ps_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign tick = in_run;
`endif

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        cfg_err_d     = cfg_err_q;
        tc_d          = 1'b0;
        ctr_load      = 1'b1;
        ctr_load_data = count_i;

        case (state_q)
            S_INIT: begin
                ctr_load_data = '0;
                state_d       = S_IDLE;
            end
            S_IDLE: begin
                if (start && !stop && !clear) begin
                    if (mod_n == CNT_W'(1)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        n_d       = mod_n;
                        cfg_err_d = 1'b0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (count_i > last) begin
                    ctr_load_data = '0;
                end else if (tick && (count_i == last)) begin
                    ctr_load_data = '0;
                    tc_d          = 1'b1;
                end else if (tick) begin
                    ctr_load = 1'b0;
                end
            end
            default: begin
                ctr_load_data = '0;
                state_d       = S_INIT;
            end
        endcase

        if (clear) begin
            ctr_load      = 1'b1;
            ctr_load_data = '0;
            tc_d          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            n_q       <= '0;
            cfg_err_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cfg_err_q <= cfg_err_d;
            tc_q      <= tc_d;
        end
    end

    assign running  = in_run;
    assign tc_pulse = tc_q;
    assign cfg_err  = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_count_ctrl.sv
`default_nettype none
// tb_mod_n_count_ctrl: directed bench driving mod_n_count_ctrl with a behavioural 4-bit loadable counter.
module tb_mod_n_count_ctrl;

`ifdef MODN_PRESCALER_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] mod_n = 4'd0;
    logic [3:0] cnt;
    logic       ctr_load;
    logic [3:0] ctr_load_data;
    logic       running;
    logic       tc_pulse;
    logic       cfg_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Loadable counter without enable; its reset is tied off, so it powers up at an arbitrary value.
    initial cnt = 4'd9;
    always @(posedge clk) cnt <= ctr_load ? ctr_load_data : cnt + 4'd1;

    mod_n_count_ctrl #(.CNT_W(4), .PRESCALE(3)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .mod_n(mod_n), .count_i(cnt), .ctr_load(ctr_load), .ctr_load_data(ctr_load_data),
        .running(running), .tc_pulse(tc_pulse), .cfg_err(cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] m);
        mod_n = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic go_idle_zero();
        stop  = 1'b1;
        clear = 1'b1;
        step();
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({ctr_load, ctr_load_data, running, tc_pulse, cfg_err} !== 8'b1_0000_000)
            $display("FAIL reset_outputs actual=%b required=%b",
                     {ctr_load, ctr_load_data, running, tc_pulse, cfg_err}, 8'b1_0000_000);
        else passed++;
        reset = 1'b0;
        step();
        total++;
        if (cnt !== 4'd0) $display("FAIL init_count actual=%0d required=0", cnt);
        else passed++;
        total++;
        if ({ctr_load, running, tc_pulse, cfg_err} !== 4'b1000)
            $display("FAIL idle_flags actual=%b required=1000", {ctr_load, running, tc_pulse, cfg_err});
        else passed++;
        step();
        total++;
        if ({cnt, ctr_load, ctr_load_data} !== 9'b0000_1_0000)
            $display("FAIL idle_hold actual=%b required=000010000", {cnt, ctr_load, ctr_load_data});
        else passed++;
    endtask

    task automatic test_mod6();
        int  v;
        logic exp_tc;
        pulse_start(4'd6);
        total++;
        if (running !== 1'b1) $display("FAIL mod6_running actual=%b required=1", running);
        else passed++;
        for (int k = 0; k < 13; k++) begin
            v = k % 6;
            for (int j = 0; j < PS; j++) begin
                exp_tc = (k > 0) && (v == 0) && (j == 0);
                total++;
                if (cnt !== 4'(v)) $display("FAIL mod6_count k=%0d j=%0d actual=%0d required=%0d", k, j, cnt, v);
                else passed++;
                total++;
                if (tc_pulse !== exp_tc) $display("FAIL mod6_tc k=%0d j=%0d actual=%b required=%b", k, j, tc_pulse, exp_tc);
                else passed++;
                step();
            end
        end
        go_idle_zero();
    endtask

    task automatic test_full_range();
        int  v;
        logic exp_tc;
        pulse_start(4'd0);
        for (int k = 0; k < 17; k++) begin
            v = k % 16;
            for (int j = 0; j < PS; j++) begin
                exp_tc = (k > 0) && (v == 0) && (j == 0);
                total++;
                if (cnt !== 4'(v) || tc_pulse !== exp_tc)
                    $display("FAIL full_seq k=%0d j=%0d actual=%0d/%b required=%0d/%b", k, j, cnt, tc_pulse, v, exp_tc);
                else passed++;
                step();
            end
        end
        go_idle_zero();
    endtask

    task automatic test_stop_restart();
        int   n;
        int   changes;
        int   exp_v;
        logic [3:0] prev;
        logic ok;
        pulse_start(4'd10);
        n = 0;
        while (cnt !== 4'd7 && n < 200) begin step(); n++; end
        total++;
        if (cnt !== 4'd7) $display("FAIL reach7 actual=%0d required=7", cnt);
        else passed++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if ({cnt, running} !== 5'b0111_0) $display("FAIL stop_freeze actual=%0d/%b required=7/0", cnt, running);
        else passed++;
        ok = 1'b1;
        repeat (20) begin step(); if (cnt !== 4'd7 || running !== 1'b0) ok = 1'b0; end
        total++;
        if (ok !== 1'b1) $display("FAIL frozen20 actual=%b required=1", ok);
        else passed++;
        pulse_start(4'd5);
        total++;
        if ({cnt, running, ctr_load, ctr_load_data} !== 10'b0111_1_1_0000)
            $display("FAIL stale_reload actual=%0d/%b/%b/%0d required=7/1/1/0", cnt, running, ctr_load, ctr_load_data);
        else passed++;
        step();
        total++;
        if ({cnt, tc_pulse} !== 5'b0000_0) $display("FAIL stale_zero actual=%0d/%b required=0/0", cnt, tc_pulse);
        else passed++;
        prev = 4'd0;
        changes = 0;
        n = 0;
        while (changes < 5 && n < 100) begin
            step();
            n++;
            if (cnt !== prev) begin
                exp_v = (int'(prev) + 1) % 5;
                total++;
                if (cnt !== 4'(exp_v) || tc_pulse !== (exp_v == 0))
                    $display("FAIL mod5_seq actual=%0d/%b required=%0d/%b", cnt, tc_pulse, exp_v, (exp_v == 0));
                else passed++;
                prev = cnt;
                changes++;
            end else begin
                total++;
                if (tc_pulse !== 1'b0) $display("FAIL mod5_tc_hold actual=%b required=0", tc_pulse);
                else passed++;
            end
        end
        total++;
        if (changes != 5) $display("FAIL mod5_timeout actual=%0d required=5", changes);
        else passed++;
    endtask

    task automatic test_cfg_err();
        int n;
        go_idle_zero();
        pulse_start(4'd6);
        n = 0;
        while (cnt !== 4'd2 && n < 50) begin step(); n++; end
        stop = 1'b1;
        step();
        stop = 1'b0;
        pulse_start(4'd1);
        total++;
        if ({cfg_err, running, cnt} !== 6'b1_0_0010)
            $display("FAIL cfg_reject actual=%b/%b/%0d required=1/0/2", cfg_err, running, cnt);
        else passed++;
        step();
        step();
        total++;
        if ({cfg_err, running, cnt} !== 6'b1_0_0010)
            $display("FAIL cfg_sticky actual=%b/%b/%0d required=1/0/2", cfg_err, running, cnt);
        else passed++;
        pulse_start(4'd4);
        total++;
        if ({cfg_err, running} !== 2'b01) $display("FAIL cfg_clear actual=%b/%b required=0/1", cfg_err, running);
        else passed++;
        go_idle_zero();
    endtask

    task automatic test_simultaneous();
        int n;
        pulse_start(4'd8);
        n = 0;
        while (cnt !== 4'd3 && n < 50) begin step(); n++; end
        total++;
        if (cnt !== 4'd3) $display("FAIL reach3 actual=%0d required=3", cnt);
        else passed++;
        clear = 1'b1;
        stop  = 1'b1;
        step();
        clear = 1'b0;
        stop  = 1'b0;
        total++;
        if ({cnt, running, tc_pulse} !== 6'b0000_0_0)
            $display("FAIL clear_stop actual=%0d/%b/%b required=0/0/0", cnt, running, tc_pulse);
        else passed++;
        step();
        total++;
        if ({cnt, running, tc_pulse} !== 6'b0000_0_0)
            $display("FAIL clear_stop_after actual=%0d/%b/%b required=0/0/0", cnt, running, tc_pulse);
        else passed++;

        pulse_start(4'd4);
        n = 0;
        while (cnt !== 4'd3 && n < 50) begin step(); n++; end
        repeat (PS - 1) step();
        total++;
        if ({cnt, ctr_load, ctr_load_data} !== 9'b0011_1_0000)
            $display("FAIL wrap_pending actual=%0d/%b/%0d required=3/1/0", cnt, ctr_load, ctr_load_data);
        else passed++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if ({cnt, tc_pulse, running} !== 6'b0000_0_1)
            $display("FAIL clear_at_last actual=%0d/%b/%b required=0/0/1", cnt, tc_pulse, running);
        else passed++;
        step();
        total++;
        if (tc_pulse !== 1'b0) $display("FAIL clear_at_last_tc actual=%b required=0", tc_pulse);
        else passed++;

        reset = 1'b1;
        #1;
        total++;
        if ({ctr_load, ctr_load_data, running, tc_pulse, cfg_err} !== 8'b1_0000_000)
            $display("FAIL reset_midrun actual=%b required=10000000",
                     {ctr_load, ctr_load_data, running, tc_pulse, cfg_err});
        else passed++;
        step();
        reset = 1'b0;
        step();
        step();
        total++;
        if ({cnt, running, ctr_load, ctr_load_data} !== 10'b0000_0_1_0000)
            $display("FAIL after_reset actual=%0d/%b/%b/%0d required=0/0/1/0", cnt, running, ctr_load, ctr_load_data);
        else passed++;
    endtask

    initial begin
        #1;
        test_reset();
        test_mod6();
        test_full_range();
        test_stop_restart();
        test_cfg_err();
        test_simultaneous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
